// File: rtl/vend_pkg.sv
// Shared encodings and coin table for the vending datapath.
// Used by the vending controller and the change dispenser.
package vend_pkg;

  localparam int IDX_W   = 2;
  localparam int N_DENOM = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_FINISH = 3'd3
  } state_t;

  // Element 0 is the largest coin; greedy search prefers low indices.
  localparam logic [N_DENOM-1:0][7:0] DENOM = {
    8'd1, 8'd2, 8'd5, 8'd10
  };

  function automatic logic [7:0] denom_of(
    input logic [IDX_W-1:0] idx
  );
    return DENOM[idx];
  endfunction

endpackage

// File: rtl/change_dispenser_ctrl_coin_bank.sv
// Per-denomination coin inventory with refill and decrement.
// Also picks the largest coin that fits the remaining amount.
module coin_bank
  import vend_pkg::*;
#(
  parameter int AMT_W    = 8,
  parameter int CNT_W    = 6,
  parameter int INIT_CNT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             refill,
  input  logic             dec,
  input  logic [IDX_W-1:0] dec_idx,
  input  logic [AMT_W-1:0] remaining,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [CNT_W-1:0] cnt [N_DENOM];

  always_ff @(posedge clk) begin
    if (reset || refill) begin
      for (int i = 0; i < N_DENOM; i++) begin
        cnt[i] <= CNT_W'(INIT_CNT);
      end
    end else if (dec && cnt[dec_idx] != '0) begin
      cnt[dec_idx] <= cnt[dec_idx] - CNT_W'(1);
    end
  end

  // Scan from smallest coin up so the lowest fitting index wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N_DENOM - 1; i >= 0; i--) begin
      if (cnt[i] != '0 &&
          AMT_W'(denom_of(IDX_W'(i))) <= remaining) begin
        found = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Returns change one coin at a time over a req/ack ejector.
// Greedy largest-first, limited by coin inventory.
module change_dispenser_ctrl
  import vend_pkg::*;
#(
  parameter int AMT_W    = 8,
  parameter int CNT_W    = 6,
  parameter int INIT_CNT = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             eject_ack,
  input  logic             refill,
  output logic             eject_req,
  output logic [1:0]       eject_sel,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining
);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] sel_q;
  logic [IDX_W-1:0] pick;
  logic             found;
  logic             accept;
  logic             ack_hit;
  logic             bank_refill;

  assign accept      = (state == ST_IDLE) && start;
  assign ack_hit     = (state == ST_EJECT) && eject_ack;
  assign bank_refill = (state == ST_IDLE) && refill;

  coin_bank #(
    .AMT_W   (AMT_W),
    .CNT_W   (CNT_W),
    .INIT_CNT(INIT_CNT)
  ) u_bank (
    .clk      (clk),
    .reset    (reset),
    .refill   (bank_refill),
    .dec      (ack_hit),
    .dec_idx  (sel_q),
    .remaining(remaining),
    .found    (found),
    .idx      (pick)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    eject_req = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nx = (change_amt == '0) ? ST_FINISH
                                        : ST_SELECT;
        end
      end
      ST_SELECT: begin
        state_nx = found ? ST_EJECT : ST_FINISH;
      end
      ST_EJECT: begin
        eject_req = 1'b1;
        if (eject_ack) state_nx = ST_SELECT;
      end
      ST_FINISH: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: begin
        busy     = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      remaining <= '0;
      short     <= 1'b0;
      sel_q     <= '0;
    end else begin
      if (accept) begin
        remaining <= change_amt;
        short     <= 1'b0;
      end
      if (state == ST_SELECT) begin
        if (found) sel_q <= pick;
        else       short <= (remaining != '0);
      end
      // Selection guaranteed the coin fits, so no underflow.
      if (ack_hit) begin
        remaining <= remaining - AMT_W'(denom_of(sel_q));
      end
    end
  end

  assign eject_sel = sel_q;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Directed and random checks of change_dispenser_ctrl
// against a greedy coin model.
module tb_change_dispenser_ctrl;

  localparam int AMT_W = 8;
  localparam int CNT_W = 6;
  localparam int INIT  = 20;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [AMT_W-1:0] change_amt;
  logic             eject_ack;
  logic             refill;
  logic             eject_req;
  logic [1:0]       eject_sel;
  logic             busy;
  logic             done;
  logic             short;
  logic [AMT_W-1:0] remaining;

  int tests = 0;
  int fails = 0;
  int den [4] = '{10, 5, 2, 1};
  int inv [4];
  int exp_q [$];
  int exp_rem;

  always #5 clk = ~clk;

  change_dispenser_ctrl #(
    .AMT_W   (AMT_W),
    .CNT_W   (CNT_W),
    .INIT_CNT(INIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .change_amt(change_amt),
    .eject_ack (eject_ack),
    .refill    (refill),
    .eject_req (eject_req),
    .eject_sel (eject_sel),
    .busy      (busy),
    .done      (done),
    .short     (short),
    .remaining (remaining)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic inv_reset();
    for (int i = 0; i < 4; i++) inv[i] = INIT;
  endtask

  // Greedy payout: biggest affordable coin still in stock.
  task automatic model(input int amt);
    int p;
    exp_q   = {};
    exp_rem = amt;
    while (1) begin
      p = -1;
      for (int i = 3; i >= 0; i--)
        if (den[i] <= exp_rem && inv[i] > 0) p = i;
      if (p < 0) break;
      exp_q.push_back(p);
      exp_rem -= den[p];
      inv[p]--;
    end
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < 4; i++)
      chk(tag, 32'(dut.u_bank.cnt[i]), INIT);
  endtask

  task automatic do_refill();
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    inv_reset();
  endtask

  task automatic run(input int amt, input int ackd,
                     input bit poke, input bit wr);
    int got;
    int cyc;
    bit fin;
    logic [1:0] s0;
    if (wr) inv_reset();
    model(amt);
    start      = 1'b1;
    change_amt = AMT_W'(amt);
    refill     = wr;
    @(negedge clk);
    start      = 1'b0;
    refill     = 1'b0;
    change_amt = AMT_W'($urandom);
    chk("busy_after_start", busy, 1);
    chk("done_lat", done, amt == 0);
    got = 0;
    fin = 0;
    cyc = 0;
    while (!fin && cyc < 2000) begin
      if (done) begin
        fin = 1;
      end else if (eject_req) begin
        if (got == 0) chk("first_req_lat", cyc, 1);
        chk("sel", eject_sel,
            got < exp_q.size() ? exp_q[got] : 9);
        s0 = eject_sel;
        got++;
        for (int k = 0; k < ackd; k++) begin
          if (poke) begin
            start  = 1'b1;
            refill = 1'b1;
          end
          @(negedge clk);
          start  = 1'b0;
          refill = 1'b0;
          cyc++;
          chk("req_hold", eject_req, 1);
          chk("sel_hold", eject_sel, s0);
        end
        eject_ack = 1'b1;
        @(negedge clk);
        eject_ack = 1'b0;
        cyc++;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("finished", fin, 1);
    chk("coin_count", got, exp_q.size());
    chk("remaining", remaining, exp_rem);
    chk("short", short, exp_rem != 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle", busy, 0);
    chk("rem_hold", remaining, exp_rem);
  endtask

  initial begin
    int n;
    reset      = 1'b1;
    start      = 1'b0;
    change_amt = '0;
    eject_ack  = 1'b0;
    refill     = 1'b0;
    inv_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_req", eject_req, 0);
    chk("rst_sel", eject_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_short", short, 0);
    chk("rst_rem", remaining, 0);
    check_counts("rst_cnt");

    run(0, 1, 0, 0);
    run(18, 1, 0, 0);

    do_refill();
    run(190, 0, 0, 0);
    run(25, 0, 0, 0);

    do_refill();
    for (int i = 0; i < 20; i++) run(5, 0, 0, 0);
    for (int i = 0; i < 20; i++) run(2, 0, 0, 0);
    for (int i = 0; i < 20; i++) run(1, 0, 0, 0);
    run(7, 0, 0, 0);
    run(0, 0, 0, 0);

    do_refill();
    run(15, 10, 1, 0);

    start      = 1'b1;
    change_amt = 8'd15;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!eject_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reach_eject", eject_req, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    inv_reset();
    chk("mid_rst_req", eject_req, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rem", remaining, 0);
    check_counts("mid_rst_cnt");
    for (int i = 0; i < 4; i++) begin
      chk("mid_rst_no_done", done, 0);
      @(negedge clk);
    end

    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 5) == 0) begin
        eject_ack = 1'b1;
        @(negedge clk);
        eject_ack = 1'b0;
      end
      if ($urandom_range(0, 7) == 0) do_refill();
      run($urandom_range(0, 80),
          $urandom_range(0, 3),
          1'($urandom_range(0, 1)),
          $urandom_range(0, 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
